// File: rtl/shift_frame_pkg.sv
// Shared types and helpers for the shift frame engine family.
//   mode_e    : transfer direction selected at frame start
//   state_e   : engine control state
//   len_valid : frame length legality check (1..max_len)
package shift_frame_pkg;

    typedef enum logic [1:0] {
        MODE_RX     = 2'b00,
        MODE_TX     = 2'b01,
        MODE_DUPLEX = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic len_valid(input logic [31:0] len_val,
                                       input logic [31:0] max_len);
        return (len_val >= 32'd1) && (len_val <= max_len);
    endfunction

endpackage

// File: rtl/shift_bit_index.sv
// Maps the running bit count of a frame onto the buffer bit it addresses.
//   count     : bits already moved in this frame
//   len       : frame length in bits
//   msb_first : 1 walks from bit len-1 down to 0, 0 walks from bit 0 up
//   idx       : buffer bit for the current shift
module shift_bit_index #(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] len,
    input  logic             msb_first,
    output logic [CNT_W-1:0] idx
);

    always_comb begin
        if (msb_first) begin
            idx = len - count - CNT_W'(1);
        end else begin
            idx = count;
        end
    end

endmodule

// File: rtl/shift_frame_engine.sv
// Serial frame engine: deserialise (RX), serialise (TX) or full duplex,
// with per-frame length and bit order and a start/enable/done handshake.
//   clk, reset : clock and asynchronous active-high reset
//   start      : frame request, honoured only in IDLE
//   mode       : 00 RX, 01 TX, 10 DUPLEX, 11 reserved (latched at start)
//   len        : frame length 1..WIDTH (latched at start)
//   msb_first  : bit order (latched at start)
//   enable     : shift strobe, one bit per enabled SHIFT cycle
//   s_in       : serial input
//   p_in       : parallel load data, low len bits used
//   s_out      : registered serial output, holds between frames
//   p_out      : last received frame, zero above len
//   p_valid    : pulse when p_out is updated
//   busy       : high while shifting
//   done       : pulse at frame end
//   err        : pulse when a start request is rejected
module shift_frame_engine
    import shift_frame_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] len,
    input  logic             msb_first,
    input  logic             enable,
    input  logic             s_in,
    input  logic [WIDTH-1:0] p_in,
    output logic             s_out,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             msb_q, msb_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             s_out_q, s_out_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             p_valid_q, p_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] bit_sel;
    logic [WIDTH-1:0] upd_buf;
    logic             cur_bit;
    mode_e            mode_in;

    shift_bit_index #(
        .CNT_W(CNT_W)
    ) u_idx (
        .count    (count_q),
        .len      (len_q),
        .msb_first(msb_q),
        .idx      (idx)
    );

    assign mode_in = mode_e'(mode);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        msb_d     = msb_q;
        count_d   = count_q;
        buf_d     = buf_q;
        s_out_d   = s_out_q;
        p_out_d   = p_out_q;
        p_valid_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // One-hot select avoids an over-wide dynamic index into the buffer.
        bit_sel = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
        cur_bit = |(buf_q & bit_sel);

        // Received bit merged into the buffer; in DUPLEX cur_bit is read
        // from buf_q, i.e. before this merge.
        upd_buf = buf_q;
        if (mode_q != MODE_TX) begin
            upd_buf = s_in ? (buf_q | bit_sel) : (buf_q & ~bit_sel);
        end

        if (state_q == ST_IDLE) begin
            if (start) begin
                if ((mode_in != MODE_RSVD) && len_valid(32'(len), 32'(WIDTH))) begin
                    state_d = ST_SHIFT;
                    mode_d  = mode_in;
                    len_d   = len;
                    msb_d   = msb_first;
                    count_d = '0;
                    buf_d   = (mode_in == MODE_RX) ? '0 : (p_in & ~({WIDTH{1'b1}} << len));
                end else begin
                    err_d = 1'b1;
                end
            end
        end else begin
            if (enable) begin
                if (mode_q != MODE_RX) begin
                    s_out_d = cur_bit;
                end
                buf_d   = upd_buf;
                count_d = count_q + CNT_W'(1);
                if (count_q == len_q - CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (mode_q != MODE_TX) begin
                        p_out_d   = upd_buf;
                        p_valid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_RX;
            len_q     <= '0;
            msb_q     <= 1'b0;
            count_q   <= '0;
            buf_q     <= '0;
            s_out_q   <= 1'b0;
            p_out_q   <= '0;
            p_valid_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            msb_q     <= msb_d;
            count_q   <= count_d;
            buf_q     <= buf_d;
            s_out_q   <= s_out_d;
            p_out_q   <= p_out_d;
            p_valid_q <= p_valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign s_out   = s_out_q;
    assign p_out   = p_out_q;
    assign p_valid = p_valid_q;
    assign busy    = (state_q == ST_SHIFT);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_shift_frame_engine.sv
// Bench for shift_frame_engine (WIDTH=8): directed vector table,
// hand-written error/reset sequences and randomized frames against a
// reference model built from the bit-order rules.
module tb_shift_frame_engine;
    import shift_frame_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] len = 4'd0;
    logic       msb_first = 1'b0;
    logic       enable = 1'b0;
    logic       s_in = 1'b0;
    logic [7:0] p_in = 8'h00;
    logic       s_out;
    logic [7:0] p_out;
    logic       p_valid;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;

    // Model state carried between frames.
    logic       mdl_last_sout;
    logic [7:0] mdl_pout;

    shift_frame_engine #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
        .msb_first(msb_first), .enable(enable), .s_in(s_in), .p_in(p_in),
        .s_out(s_out), .p_out(p_out), .p_valid(p_valid), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  m;
        int          l;
        logic        msb;
        logic [7:0]  pin;
        logic [7:0]  sseq;
        logic [15:0] en_pat;
        int          exp_cyc;
        logic [7:0]  exp_sout;
        logic [7:0]  exp_pout;
        logic        exp_pv;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives start there, so a call made in the done
    // cycle of the previous frame exercises back-to-back acceptance.
    // sseq/sout_seq are time ordered: bit k is the k-th enabled shift.
    task automatic run_frame(input logic [1:0] m, input int l, input logic msb,
                             input logic [7:0] pin, input logic [7:0] sseq,
                             input logic [15:0] en_pat,
                             output logic [7:0] sout_seq, output logic [7:0] pout,
                             output logic pv, output logic dn, output logic busy0,
                             output int early, output int cyc);
        int   k;
        logic en;
        sout_seq = '0;
        early = 0;
        start = 1'b1; mode = m; len = 4'(l); msb_first = msb; p_in = pin; enable = 1'b0;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy & ~done;
        k = 0;
        cyc = 0;
        while (k < l && cyc < 100) begin
            en = (cyc < 16) ? en_pat[cyc] : 1'b1;
            enable = en;
            s_in = en ? sseq[k] : ~sseq[k];
            @(negedge clk);
            cyc++;
            if (en) begin
                sout_seq[k] = s_out;
                k++;
            end
            if (k < l && (done || p_valid || !busy)) early++;
        end
        enable = 1'b0;
        dn = done;
        pv = p_valid;
        pout = p_out;
        if (k < l) early++;
    endtask

    function automatic void model(input logic [1:0] m, input int l, input logic msb,
                                  input logic [7:0] pin, input logic [7:0] sseq,
                                  input logic last_in, input logic [7:0] pout_in,
                                  output logic [7:0] exp_sout, output logic [7:0] exp_pout,
                                  output logic exp_pv);
        logic [7:0] rx;
        int         b;
        rx = '0;
        exp_sout = '0;
        for (int k = 0; k < l; k++) begin
            b = msb ? (l - 1 - k) : k;
            exp_sout[k] = (m == 2'b00) ? last_in : pin[b];
            rx[b] = sseq[k];
        end
        exp_pv = (m != 2'b01);
        exp_pout = exp_pv ? rx : pout_in;
    endfunction

    task automatic frame_check(input string tag, input logic [1:0] m, input int l,
                               input logic msb, input logic [7:0] pin, input logic [7:0] sseq,
                               input logic [15:0] en_pat, input int exp_cyc,
                               input logic [7:0] exp_sout, input logic [7:0] exp_pout,
                               input logic exp_pv);
        logic [7:0] so, po, mask;
        logic       pv, dn, b0;
        int         early, cyc;
        run_frame(m, l, msb, pin, sseq, en_pat, so, po, pv, dn, b0, early, cyc);
        mask = 8'hFF >> (8 - l);
        check({tag, "_busy_after_start"}, 32'(b0), 32'd1);
        check({tag, "_no_early_end"}, 32'(early), 32'd0);
        if (exp_cyc >= 0) check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_done"}, 32'(dn), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_p_valid"}, 32'(pv), 32'(exp_pv));
        check({tag, "_p_out"}, 32'(po), 32'(exp_pout));
        check({tag, "_s_out_seq"}, 32'(so & mask), 32'(exp_sout & mask));
    endtask

    task automatic model_frame(input string tag, input logic [1:0] m, input int l,
                               input logic msb, input logic [7:0] pin,
                               input logic [7:0] sseq, input logic [15:0] en_pat);
        logic [7:0] es, ep;
        logic       epv;
        model(m, l, msb, pin, sseq, mdl_last_sout, mdl_pout, es, ep, epv);
        frame_check(tag, m, l, msb, pin, sseq, en_pat, (en_pat == 16'hFFFF) ? l : -1, es, ep, epv);
        mdl_last_sout = es[l-1];
        mdl_pout = ep;
    endtask

    initial begin
        logic [1:0] rm;
        int         rl;
        int         hits;

        vecs[0] = '{2'b00, 5, 1'b0, 8'h00, 8'h13, 16'hFFFF, 5, 8'h00, 8'h13, 1'b1};
        vecs[1] = '{2'b01, 8, 1'b1, 8'hA5, 8'hFF, 16'hFFFF, 8, 8'hA5, 8'h13, 1'b0};
        vecs[2] = '{2'b10, 4, 1'b1, 8'h0C, 8'h06, 16'hFFFF, 4, 8'h03, 8'h06, 1'b1};
        vecs[3] = '{2'b00, 4, 1'b0, 8'h00, 8'h0D, 16'h0059, 7, 8'h00, 8'h0D, 1'b1};

        repeat (2) @(negedge clk);
        check("reset_outputs", {21'd0, s_out, p_out, p_valid, busy, done, err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {28'd0, p_valid, busy, done, err}, 32'd0);

        // Directed table, frames chained back-to-back.
        for (int i = 0; i < 4; i++) begin
            frame_check($sformatf("vec%0d", i), vecs[i].m, vecs[i].l, vecs[i].msb,
                        vecs[i].pin, vecs[i].sseq, vecs[i].en_pat, vecs[i].exp_cyc,
                        vecs[i].exp_sout, vecs[i].exp_pout, vecs[i].exp_pv);
        end
        @(negedge clk);
        check("pulses_drop", {29'd0, done, p_valid, busy}, 32'd0);

        // Rejected starts: len=0, len=9, reserved mode.
        hits = 0;
        start = 1'b1; mode = 2'b00; len = 4'd0;
        @(negedge clk);
        check("err_len0", {30'd0, err, busy}, 32'd2);
        len = 4'd9;
        @(negedge clk);
        check("err_len9", {30'd0, err, busy}, 32'd2);
        mode = 2'b11; len = 4'd4;
        @(negedge clk);
        check("err_mode11", {30'd0, err, busy}, 32'd2);
        start = 1'b0; mode = 2'b00;
        @(negedge clk);
        check("err_drops", {30'd0, err, busy}, 32'd0);

        // Reset after 3 of 8 TX bits.
        start = 1'b1; mode = 2'b01; len = 4'd8; msb_first = 1'b1; p_in = 8'hFF;
        @(negedge clk);
        start = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_shift", {30'd0, s_out, busy}, 32'd3);
        #2 reset = 1'b1;
        #1 check("async_reset_clear", {21'd0, s_out, p_out, p_valid, busy, done, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) hits++;
        end
        enable = 1'b0;
        check("no_done_after_reset", 32'(hits), 32'd0);

        // Frames after reset (back-to-back), then randomized frames.
        mdl_last_sout = 1'b0;
        mdl_pout = 8'h00;
        model_frame("post_rst_tx", 2'b01, 6, 1'b0, 8'h2D, 8'h00, 16'hFFFF);
        model_frame("post_rst_dup", 2'b10, 1, 1'b1, 8'h01, 8'h01, 16'hFFFF);
        for (int i = 0; i < 40; i++) begin
            rm = 2'($urandom_range(0, 2));
            rl = $urandom_range(1, 8);
            model_frame($sformatf("rand%0d", i), rm, rl, 1'($urandom),
                        8'($urandom), 8'($urandom), 16'($urandom | $urandom));
        end
        @(negedge clk);
        check("final_idle", {29'd0, done, p_valid, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_frame_engine.md
Name: shift_frame_engine

Overview:
- Parametrised successor to the team's single-mode serial shift block.
- One engine covers deserialise (RX), serialise (TX) and full-duplex (SPI-style) operation.
- Frame length is selectable per transfer, bit order is selectable, and a start/enable/done handshake frames each transfer.
- Sits between serial link front-ends and parallel datapath registers.

Parameters:
- WIDTH, 8, maximum frame length in bits (>=2).
- CNT_W, $clog2(WIDTH+1), width of the length field and the bit counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- start  in  1  request a new frame; sampled only in IDLE.
- mode  in  2  00 RX, 01 TX, 10 DUPLEX, 11 reserved; latched at start.
- len  in  CNT_W  frame length 1..WIDTH; latched at start.
- msb_first  in  1  1: bit len-1 first; 0: bit 0 first; latched at start.
- enable  in  1  shift strobe; one bit is moved per enabled SHIFT cycle.
- s_in  in  1  serial data in.
- p_in  in  WIDTH  parallel load data; low len bits used.
- s_out  out  1  registered serial data out.
- p_out  out  WIDTH  received frame, zero-extended above len.
- p_valid  out  1  one-cycle pulse: p_out updated.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  one-cycle pulse: start rejected.

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. All outputs, the buffer, the bit counter and the latched fields clear to 0; state returns to IDLE. Reset mid-frame aborts the frame with no done pulse.
- States: IDLE, SHIFT.
- IDLE, start=1, mode!=11, 1<=len<=WIDTH:
  - Latch mode, len and msb_first.
  - buf <= p_in with bits >=len masked to 0 (TX/DUPLEX), or buf <= 0 (RX).
  - count <= 0; next state SHIFT; busy=1 from the next cycle.
- IDLE, start=1 with invalid mode or len (0 or >WIDTH): err=1 next cycle; state stays IDLE.
- start while in SHIFT is ignored; no err is raised.
- Bit index: idx = msb_first ? (len-1-count) : count.
- SHIFT with enable=1, one bit per edge:
  - TX/DUPLEX: s_out <= buf[idx].
  - RX/DUPLEX: buf[idx] <= s_in. In DUPLEX the read uses the pre-update value.
  - count <= count+1.
- SHIFT with enable=0: hold everything. busy stays 1 and s_out holds.
- Last shift (count==len-1, enable=1), on the same edge:
  - state <= IDLE; busy <= 0; done <= 1.
  - RX/DUPLEX: p_out <= updated buf and p_valid <= 1. TX: p_out unchanged and p_valid stays 0.
- Latency: the first s_out bit is visible 1 cycle after the first enabled SHIFT edge. done appears len enabled cycles after entering SHIFT (plus any stall cycles).
- Back-to-back frames: start asserted in the cycle done is high is accepted, because the engine is already in IDLE. Zero dead cycles between frames.
- s_out holds its last value in IDLE. p_out holds until the next RX/DUPLEX completion.
- done, p_valid and err are single-cycle pulses that deassert on the next edge.
- len=1: a single enabled shift completes the frame.

Decomposition:
- Package shift_frame_pkg:
  - mode enum (MODE_RX, MODE_TX, MODE_DUPLEX, MODE_RSVD).
  - state enum (ST_IDLE, ST_SHIFT).
  - len-valid check function.
- Sub-module shift_bit_index: combinational mapping of count, len and msb_first to idx. It is reused by other serial blocks.
- All sequential logic stays in shift_frame_engine.

Test Plan:
- WIDTH=8, TX, len=8, msb_first=1, p_in=0xA5, enable held 1 -> s_out sequence 1,0,1,0,0,1,0,1; done pulses on the 9th cycle after start; p_valid stays 0.
- RX, len=5, msb_first=0, s_in sequence 1,1,0,0,1 -> p_out=0x13; p_valid and done pulse together; busy low in the same cycle.
- DUPLEX, len=4, msb_first=1, p_in=0x0C, s_in 0,1,1,0 -> s_out 1,1,0,0; p_out=0x06.
- RX, len=4 with enable toggling 1,0,0,1,1,0,1 -> exactly 4 bits are captured; busy stays high throughout the stalls; done follows the 4th enabled edge.
- start with len=0, then len=9, then mode=11 -> err pulses 3 times; busy never rises.
- Reset asserted after 3 of 8 TX bits -> all outputs 0 immediately and no done. A new frame after reset completes normally; start in the done cycle begins the next frame with no gap.
